// File: rtl/instruction_fetch_types.sv
// Shared types and constants for the instruction fetch block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_fetch_types;

  // Default first fetch address after reset.
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  // RISC-V canonical NOP (addi x0, x0, 0), shown while no instruction is valid.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One fetched instruction paired with the address it came from.
  typedef struct packed {
    logic [31:0] instruction;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of a parameterised entry type with flush.
// Latency: head is a direct read of the oldest entry; a push is visible the next cycle.
// Backpressure: none internally; the caller must never push when full or pop when empty.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop all entries (wins over a simultaneous push)
//   push, push_data   write one entry
//   pop               discard the head entry
//   head              oldest entry (undefined when count == 0)
//   count             number of entries held, 0..DEPTH
module fetch_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [63:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues sequential PCs to memory, pairs in-order responses with
// their PCs, buffers them and presents one latched instruction per cycle to decode.
// Latency: 1 cycle from memory response to output registers when the buffer is empty.
// Backpressure: stall_in freezes the outputs; issue is throttled by a credit cap on
// in-flight + to-be-dropped + buffered responses, so the buffer can never overflow.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_resp_valid/data          in-order response channel from memory
//   stall_in                      decode stall, outputs hold
//   branch_reset, branch_target   redirect from execute
//   pc_output_valid, instruction, instruction_pc   latched output to decode
module instruction_fetch
  import instruction_fetch_types::*;
#(
  parameter logic [63:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall_in,
  input  logic        branch_reset,
  input  logic [63:0] branch_target,
  output logic        pc_output_valid,
  output logic [31:0] instruction,
  output logic [63:0] instruction_pc
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = CNT_W + 2;

  logic [63:0]      pc_q;
  logic [63:0]      pcq_head;
  logic [CNT_W-1:0] pcq_count;
  logic [CNT_W-1:0] resp_count;
  logic [CNT_W-1:0] drop_count;
  logic [SUM_W-1:0] credit_used;
  fetch_entry_t     resp_entry;
  fetch_entry_t     resp_head;
  logic             req_fire;
  logic             resp_drop;
  logic             resp_keep;
  logic             resp_empty;
  logic             resp_bypass;
  logic             resp_push;
  logic             resp_pop;

  // Every issued request holds a credit until its response leaves the buffer
  // (or is dropped), which is what bounds the response FIFO.
  assign credit_used    = SUM_W'(pcq_count) + SUM_W'(drop_count) + SUM_W'(resp_count);
  assign imem_req_valid = !rst && !branch_reset && (credit_used < SUM_W'(MAX_OUTSTANDING));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses to requests issued before a redirect are stale and discarded.
  assign resp_drop   = imem_resp_valid && (branch_reset || (drop_count != '0));
  assign resp_keep   = imem_resp_valid && !resp_drop;
  assign resp_entry  = '{instruction: imem_resp_data, pc: pcq_head};
  assign resp_empty  = (resp_count == '0);
  assign resp_bypass = resp_keep && !stall_in && resp_empty;
  assign resp_push   = resp_keep && !resp_bypass;
  assign resp_pop    = !branch_reset && !stall_in && !resp_empty;

  // PCs of live (non-stale) in-flight requests; flushed on redirect because the
  // stale ones are then tracked by drop_count alone.
  fetch_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .entry_t (logic [63:0])
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_reset),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (resp_keep),
    .head      (pcq_head),
    .count     (pcq_count)
  );

  fetch_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .entry_t (fetch_entry_t)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_reset),
    .push      (resp_push),
    .push_data (resp_entry),
    .pop       (resp_pop),
    .head      (resp_head),
    .count     (resp_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (branch_reset) begin
      pc_q <= branch_target & ~64'd3;
    end else if (req_fire) begin
      pc_q <= pc_q + 64'd4;
    end
  end

  // On redirect every request still in flight becomes stale, except one whose
  // response is arriving right now (it is discarded this cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (branch_reset) begin
      drop_count <= CNT_W'(SUM_W'(pcq_count) + SUM_W'(drop_count) - SUM_W'(imem_resp_valid));
    end else if (resp_drop) begin
      drop_count <= drop_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_output_valid <= 1'b0;
      instruction     <= NOP_INSTR;
      instruction_pc  <= '0;
    end else if (branch_reset) begin
      pc_output_valid <= 1'b0;
    end else if (!stall_in) begin
      if (!resp_empty) begin
        pc_output_valid <= 1'b1;
        instruction     <= resp_head.instruction;
        instruction_pc  <= resp_head.pc;
      end else if (resp_bypass) begin
        pc_output_valid <= 1'b1;
        instruction     <= resp_entry.instruction;
        instruction_pc  <= resp_entry.pc;
      end else begin
        pc_output_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a fixed-latency in-order memory model.
// Latency: memory answers each accepted request exactly lat cycles later.
// Backpressure: imem_req_ready and stall_in are driven from the directed sequence.
module tb_instruction_fetch;
  import instruction_fetch_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall_in;
  logic        branch_reset;
  logic [63:0] branch_target;
  logic        pc_output_valid;
  logic [31:0] instruction;
  logic [63:0] instruction_pc;

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall_in        (stall_in),
    .branch_reset    (branch_reset),
    .branch_target   (branch_target),
    .pc_output_valid (pc_output_valid),
    .instruction     (instruction),
    .instruction_pc  (instruction_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] addr;
  } mreq_t;

  mreq_t mq[$];
  int    cyc;
  int    lat;
  int    max_inflight;
  logic  last_rv;
  int    tests_run;
  int    tests_failed;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_out(input string tag, input logic [63:0] pc);
    check({tag, "_valid"}, 64'(pc_output_valid), 64'd1);
    check({tag, "_pc"}, instruction_pc, pc);
    check({tag, "_instr"}, 64'(instruction), 64'(instr_of(pc)));
  endtask

  // One clock cycle: drive the due response, note acceptance just before the
  // edge, update the memory model, then return at the falling edge.
  task automatic step();
    logic        rv;
    logic        acc;
    logic [63:0] acc_a;
    rv = (mq.size() > 0) && (mq[0].due == cyc);
    imem_resp_valid = rv;
    imem_resp_data  = rv ? instr_of(mq[0].addr) : 32'h0;
    #1;
    acc   = imem_req_valid && imem_req_ready;
    acc_a = imem_req_addr;
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (rv) void'(mq.pop_front());
      if (acc) mq.push_back('{cyc + lat, acc_a});
    end
    if (mq.size() > max_inflight) max_inflight = mq.size();
    last_rv = rv;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0)
      assert (dut.resp_count <= 2)
        else $error("FAIL resp_fifo_depth count=%0d", dut.resp_count);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0; max_inflight = 0; last_rv = 1'b0;
    rst = 1'b1; stall_in = 1'b0; branch_reset = 1'b0; branch_target = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0; lat = 1;

    // Reset state
    do_reset();
    check("rst_valid", 64'(pc_output_valid), 64'd0);
    check("rst_instr", 64'(instruction), 64'h13);
    check("rst_pc", instruction_pc, 64'h0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_addr", imem_req_addr, 64'h0);
    rst = 1'b0;

    // Back-to-back stream, 1-cycle memory
    step();
    check("stream_c2_valid", 64'(pc_output_valid), 64'd0);
    for (int k = 2; k <= 6; k++) begin
      step();
      expect_out("stream", 64'(4 * (k - 2)));
    end

    // Decode stall for 5 cycles, output frozen at 0x10
    stall_in = 1'b1;
    for (int k = 7; k <= 11; k++) begin
      step();
      expect_out("stall_hold", 64'h10);
    end
    stall_in = 1'b0;
    for (int k = 12; k <= 15; k++) begin
      step();
      expect_out("stall_release", 64'h14 + 64'(4 * (k - 12)));
    end

    // Memory not ready for 4 cycles
    imem_req_ready = 1'b0;
    step();
    expect_out("rdy_low_first", 64'h24);
    check("rdy_low_addr", imem_req_addr, 64'h28);
    for (int k = 17; k <= 19; k++) begin
      step();
      check("rdy_low_valid", 64'(pc_output_valid), 64'd0);
      check("rdy_low_addr", imem_req_addr, 64'h28);
    end
    imem_req_ready = 1'b1;
    step();
    check("rdy_resume_gap", 64'(pc_output_valid), 64'd0);
    step();
    expect_out("rdy_resume_a", 64'h28);
    step();
    expect_out("rdy_resume_b", 64'h2C);

    // 3-cycle memory, reset applied mid-stream
    lat = 3;
    do_reset();
    rst = 1'b0;
    max_inflight = 0;
    repeat (3) step();
    step();
    expect_out("lat3_a", 64'h0);
    step();
    expect_out("lat3_b", 64'h4);
    step();
    check("lat3_gap", 64'(pc_output_valid), 64'd0);

    // Redirect with two requests (0x8, 0xC) in flight
    branch_reset = 1'b1; branch_target = 64'h1003;
    step();
    branch_reset = 1'b0;
    check("br_valid", 64'(pc_output_valid), 64'd0);
    check("br_addr", imem_req_addr, 64'h1000);
    for (int k = 8; k <= 11; k++) begin
      step();
      check("br_drop_valid", 64'(pc_output_valid), 64'd0);
    end
    step();
    expect_out("br_first", 64'h1000);
    step();
    expect_out("br_second", 64'h1004);
    repeat (2) step();
    step();
    expect_out("br_third", 64'h1008);

    // Redirect coincident with a response while stalled
    branch_reset = 1'b1; branch_target = 64'h2000; stall_in = 1'b1;
    step();
    branch_reset = 1'b0; stall_in = 1'b0;
    check("br2_coincident_resp", 64'(last_rv), 64'd1);
    check("br2_valid", 64'(pc_output_valid), 64'd0);
    check("br2_addr", imem_req_addr, 64'h2000);
    for (int k = 18; k <= 20; k++) begin
      step();
      check("br2_drop_valid", 64'(pc_output_valid), 64'd0);
    end
    step();
    expect_out("br2_first", 64'h2000);
    step();
    expect_out("br2_second", 64'h2004);

    check("max_inflight", 64'(max_inflight), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
